// File: rtl/trade_pkg.sv
// Shared types and constants for the order scheduler slice.
package trade_pkg;
  localparam int POS_W = 9;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_COOL = 2'd2,
    S_HALT = 2'd3
  } state_e;

  typedef logic signed [POS_W-1:0] pos_t;
endpackage

// File: rtl/order_scheduler_if.sv
// Order offer bus: scheduler offers, downstream accepts with order_ready.
interface order_scheduler_if;
  logic       order_valid;
  logic       order_ready;
  logic       order_side;
  logic [7:0] order_price;
  logic [3:0] order_qty;

  modport master (output order_valid, order_side, order_price, order_qty,
                  input  order_ready);
  modport slave  (input  order_valid, order_side, order_price, order_qty,
                  output order_ready);
endinterface

// File: rtl/order_scheduler_timer.sv
// 8-bit down-counter shared between ack-timeout and cooldown counting.
module order_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [7:0] cnt_q, cnt_d;

  // next count: load wins, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && cnt_q != 0) cnt_d = cnt_q - 8'd1;
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 8'd0);
endmodule

// File: rtl/order_scheduler.sv
// Order scheduler: turns buy/sell decisions into handshaked orders with
// position limits, post-order cooldown, ack timeout and a kill switch.
module order_scheduler
  import trade_pkg::*;
#(
  parameter int MAX_POS   = 16,
  parameter int ORDER_QTY = 1,
  parameter int COOLDOWN  = 4,
  parameter int TIMEOUT   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                kill,
  input  logic                buy_signal,
  input  logic                sell_signal,
  input  logic [7:0]          price,
  order_scheduler_if.master   ord,
  output logic signed [POS_W-1:0] position,
  output logic                limit_hit,
  output logic                halted,
  output logic                timeout_err
);
  // Limit checks are done one bit wider so pos+qty cannot wrap.
  localparam logic signed [POS_W:0] QTY_S = ORDER_QTY[POS_W:0];
  localparam logic signed [POS_W:0] MAX_S = MAX_POS[POS_W:0];
  // Timer is loaded with N-1 and expires on the edge it reads zero,
  // giving exactly N cycles in the state.
  localparam logic [7:0] TO_LD = 8'(TIMEOUT - 1);
  localparam logic [7:0] CD_LD = (COOLDOWN == 0) ? 8'd0 : 8'(COOLDOWN - 1);

  state_e     state_q, state_d;
  logic       side_q, side_d;
  logic [7:0] price_q, price_d;
  pos_t       pos_q, pos_d;
  logic       valid_q, lim_q, lim_d, halt_q, terr_q, terr_d;

  logic       tmr_load, tmr_dec, tmr_zero;
  logic [7:0] tmr_val;

  logic signed [POS_W:0] pos_ext, pos_buy, pos_sell;
  logic                  buy_ok, sell_ok;

  order_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // position headroom for one more order on either side
  always_comb begin
    pos_ext  = {pos_q[POS_W-1], pos_q};
    pos_buy  = pos_ext + QTY_S;
    pos_sell = pos_ext - QTY_S;
    buy_ok   = (pos_buy <= MAX_S);
    sell_ok  = (pos_sell >= -MAX_S);
  end

  // next-state and datapath decisions
  always_comb begin
    state_d  = state_q;
    side_d   = side_q;
    price_d  = price_q;
    pos_d    = pos_q;
    lim_d    = 1'b0;
    terr_d   = terr_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    tmr_dec  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kill) begin
          state_d = S_HALT;
        end else if (enable && (buy_signal ^ sell_signal)) begin
          if (buy_signal ? buy_ok : sell_ok) begin
            state_d  = S_REQ;
            side_d   = buy_signal ? SIDE_BUY : SIDE_SELL;
            price_d  = price;
            tmr_load = 1'b1;
            tmr_val  = TO_LD;
          end else begin
            lim_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        // a handshake completes even when kill lands on the same edge
        if (ord.order_ready) begin
          pos_d = (side_q == SIDE_BUY) ? pos_buy[POS_W-1:0] : pos_sell[POS_W-1:0];
          if (kill)               state_d = S_HALT;
          else if (COOLDOWN == 0) state_d = S_IDLE;
          else begin
            state_d  = S_COOL;
            tmr_load = 1'b1;
            tmr_val  = CD_LD;
          end
        end else if (kill) begin
          state_d = S_HALT;
        end else if (tmr_zero) begin
          state_d = S_HALT;
          terr_d  = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_COOL: begin
        if (kill)          state_d = S_HALT;
        else if (tmr_zero) state_d = S_IDLE;
        else               tmr_dec = 1'b1;
      end
      S_HALT: begin
        if (!kill && !enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      side_q  <= 1'b0;
      price_q <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      lim_q   <= 1'b0;
      halt_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      price_q <= price_d;
      pos_q   <= pos_d;
      valid_q <= (state_d == S_REQ);
      lim_q   <= lim_d;
      halt_q  <= (state_d == S_HALT);
      terr_q  <= terr_d;
    end
  end

  assign ord.order_valid = valid_q;
  assign ord.order_side  = side_q;
  assign ord.order_price = price_q;
  assign ord.order_qty   = ORDER_QTY[3:0];
  assign position        = pos_q;
  assign limit_hit       = lim_q;
  assign halted          = halt_q;
  assign timeout_err     = terr_q;
endmodule

// File: tb/tb_order_scheduler.sv
// Randomized scoreboard bench for order_scheduler.
module tb_order_scheduler;
  localparam int MAXP = 4;
  localparam int QTY  = 2;
  localparam int CD   = 3;
  localparam int TO   = 10;

  logic clk = 1'b0;
  logic rst, enable, kill, buy, sell;
  logic [7:0] price;
  logic signed [8:0] position;
  logic limit_hit, halted, timeout_err;

  order_scheduler_if bus();

  order_scheduler #(.MAX_POS(MAXP), .ORDER_QTY(QTY), .COOLDOWN(CD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .kill(kill),
    .buy_signal(buy), .sell_signal(sell), .price(price),
    .ord(bus), .position(position), .limit_hit(limit_hit),
    .halted(halted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic side; logic [7:0] price; int pos; } exp_t;
  exp_t oq[$];
  int   lq[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   mpos = 0;
  int   mterr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // monitor: pops expected orders on handshake and expected rejects on limit_hit
  bit pos_chk = 0;
  int pos_exp = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (pos_chk) begin
        chk("hs_position", position, pos_exp);
        pos_chk = 0;
      end
      if (bus.order_valid && bus.order_ready) begin
        if (oq.size() == 0) chk("unexpected_order", 1, 0);
        else begin
          exp_t e;
          e = oq.pop_front();
          chk("order_side", bus.order_side, e.side);
          chk("order_price", bus.order_price, e.price);
          chk("order_qty", bus.order_qty, QTY);
          pos_exp = e.pos;
          pos_chk = 1;
        end
      end
      if (limit_hit) begin
        if (lq.size() == 0) chk("unexpected_limit", 1, 0);
        else chk("limit_cycle", cyc, lq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // halt must hold with enable high, and release only with kill=0 & enable=0
  task automatic release_halt();
    kill = 0; enable = 1; buy = 1; sell = 0;
    step();
    chk("halt_hold", halted, 1);
    chk("halt_no_valid", bus.order_valid, 0);
    buy = 0; enable = 0;
    step();
    chk("halt_release", halted, 0);
    chk("terr_sticky", timeout_err, mterr);
    enable = 1;
  endtask

  task automatic issue(input bit is_buy, input int dly, input bit kill_hs);
    logic [7:0] p;
    bit ok;
    p = 8'($urandom);
    chk("idle_valid", bus.order_valid, 0);
    price = p; buy = is_buy; sell = !is_buy;
    ok = is_buy ? (mpos + QTY <= MAXP) : (mpos - QTY >= -MAXP);
    if (!ok) begin
      step();
      lq.push_back(cyc);
      buy = 0; sell = 0;
      chk("reject_no_valid", bus.order_valid, 0);
      step();
      chk("reject_position", position, mpos);
    end else begin
      mpos += is_buy ? QTY : -QTY;
      oq.push_back('{is_buy, p, mpos});
      step();
      buy = 0; sell = 0; price = 8'($urandom);
      enable = 1'($urandom_range(0, 1));
      chk("valid_latency", bus.order_valid, 1);
      repeat (dly) begin
        step();
        price = 8'($urandom);
      end
      bus.order_ready = 1; kill = kill_hs;
      step();
      bus.order_ready = 0;
      if (kill_hs) begin
        chk("kill_halted", halted, 1);
        release_halt();
      end else begin
        enable = 1;
        // signals during cooldown must be dropped
        repeat (CD) begin
          buy = 1'($urandom_range(0, 1));
          sell = 1'($urandom_range(0, 1));
          step();
        end
        buy = 0; sell = 0;
      end
    end
  endtask

  task automatic timeout_case();
    int n;
    bit b;
    chk("idle_valid", bus.order_valid, 0);
    b = (mpos + QTY <= MAXP);
    buy = b; sell = !b; price = 8'($urandom);
    step();
    buy = 0; sell = 0;
    n = 0;
    while (bus.order_valid && n < 300) begin
      n++;
      step();
    end
    chk("timeout_len", n, TO);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_halted", halted, 1);
    chk("timeout_position", position, mpos);
    mterr = 1;
    release_halt();
  endtask

  initial begin
    rst = 1; enable = 0; kill = 0; buy = 0; sell = 0; price = 0;
    bus.order_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.order_valid, 0);
    chk("rst_position", position, 0);
    chk("rst_side", bus.order_side, 0);
    chk("rst_price", bus.order_price, 0);
    chk("rst_limit", limit_hit, 0);
    chk("rst_halted", halted, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 0; enable = 1;
    step();

    for (int i = 0; i < 70; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r <= 5) issue(1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'b0);
      else if (r == 6) begin
        buy = 1; sell = 1; price = 8'($urandom);
        step();
        buy = 0; sell = 0;
        chk("both_no_valid", bus.order_valid, 0);
        step();
      end else if (r == 7) begin
        enable = 0; buy = 1;
        step();
        buy = 0; enable = 1;
        chk("disabled_no_valid", bus.order_valid, 0);
      end else if (r == 8) begin
        kill = 1;
        step();
        chk("kill_idle_halted", halted, 1);
        release_halt();
      end else if (r == 9) begin
        if (mpos + QTY <= MAXP) issue(1'b1, $urandom_range(0, 3), 1'b1);
        else issue(1'b0, $urandom_range(0, 3), 1'b1);
      end else if (r == 10) timeout_case();
      else repeat ($urandom_range(1, 4)) step();
    end

    // asynchronous reset in the middle of an offer
    repeat (2) step();
    chk("idle_valid", bus.order_valid, 0);
    if (mpos + QTY <= MAXP) begin buy = 1; sell = 0; end
    else begin buy = 0; sell = 1; end
    step();
    buy = 0; sell = 0;
    chk("pre_rst_valid", bus.order_valid, 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", bus.order_valid, 0);
    chk("async_rst_position", position, 0);
    chk("async_rst_terr", timeout_err, 0);
    chk("async_rst_halted", halted, 0);
    mpos = 0; mterr = 0;
    step();
    rst = 0;
    repeat (3) step();
    chk("post_rst_valid", bus.order_valid, 0);
    chk("orders_left", oq.size(), 0);
    chk("limits_left", lq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/order_scheduler.md
ORDER_SCHEDULER -- requirements
Module: order_scheduler

Interface
REQ-001 Parameter MAX_POS, default 16, SHALL be the absolute position limit in lots; legal range 1..240.
REQ-002 Parameter ORDER_QTY, default 1, SHALL be the lots per order; 4-bit, legal range 1..15.
REQ-003 Parameter COOLDOWN, default 4, SHALL be the idle cycles after each accepted order; 8-bit, 0 allowed.
REQ-004 Parameter TIMEOUT, default 32, SHALL be the max wait cycles for order_ready; 8-bit, legal range 1..255.
REQ-005 clk  input  1  SHALL be the sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-007 enable  input  1  SHALL permit new orders when high.
REQ-008 kill  input  1  SHALL be the trading kill switch.
REQ-009 buy_signal, sell_signal  input  1 each  SHALL be the registered decisions from the trade logic unit.
REQ-010 price  input  8  SHALL be the current price, unsigned.
REQ-011 order_valid  output  1  SHALL indicate an order offer.
REQ-012 order_ready  input  1  SHALL indicate downstream acceptance.
REQ-013 order_side  output  1  SHALL be 1 for buy, 0 for sell.
REQ-014 order_price  output  8  SHALL be the latched price.
REQ-015 order_qty  output  4  SHALL equal ORDER_QTY.
REQ-016 position  output  9 signed  SHALL be the net lots held.
REQ-017 limit_hit  output  1  SHALL be a one-cycle pulse when an order is rejected.
REQ-018 halted  output  1  SHALL be high while in HALT.
REQ-019 timeout_err  output  1  SHALL be a sticky flag set on ack timeout.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, COOLDOWN and HALT.
REQ-021 In IDLE with enable=1 and kill=0, exactly one of buy_signal/sell_signal high SHALL latch side and price and enter REQ next edge; order_valid rises one cycle after the sampled signal.
REQ-022 In IDLE, buy_signal and sell_signal high together SHALL be ignored: no order, no limit_hit.
REQ-023 A buy SHALL be rejected if position+ORDER_QTY > MAX_POS, and a sell if position-ORDER_QTY < -MAX_POS; a reject pulses limit_hit for one cycle and the FSM stays in IDLE.
REQ-024 In REQ, order_valid SHALL be high and order_side, order_price and order_qty SHALL stay stable until the handshake completes.
REQ-025 On order_valid & order_ready, position SHALL update by ±ORDER_QTY at that edge, and the FSM SHALL enter COOLDOWN, or IDLE if COOLDOWN=0.
REQ-026 COOLDOWN SHALL last exactly COOLDOWN cycles and then return to IDLE; signals during COOLDOWN are dropped.
REQ-027 In REQ, if TIMEOUT cycles elapse with no order_ready, the FSM SHALL drop order_valid, set timeout_err and enter HALT, leaving position unchanged.
REQ-028 kill=1 in any state SHALL enter HALT at the next edge; if it coincides with a handshake, the handshake SHALL complete and update position first.
REQ-029 HALT SHALL return to IDLE only when kill=0 and enable=0 at the same edge; timeout_err SHALL clear only on reset.
REQ-030 enable falling in REQ or COOLDOWN SHALL NOT abort the sequence in progress.

Reset
REQ-031 rst SHALL force IDLE, position=0, order_valid=0, order_side=0, order_price=0, limit_hit=0, halted=0, timeout_err=0 and clear all counters, independent of clk.
REQ-032 A reset asserted mid-REQ SHALL drop order_valid immediately and discard the pending order.

Structure
REQ-033 The state enum, side constants (SIDE_BUY=1, SIDE_SELL=0) and the position width SHALL live in the shared package trade_pkg.
REQ-034 One 8-bit down-counter sub-module, order_timer, SHALL be shared between cooldown and timeout counting.

Verification
REQ-035 With defaults, a buy pulse at price=100 and order_ready tied high: order_valid high one cycle later with side=1 and price=100; position becomes 1; next order accepted no earlier than 4 cycles after the handshake.
REQ-036 With MAX_POS=2, three buys with ready=1 and cooldowns elapsed: position reaches 2, the third buy pulses limit_hit and order_valid stays 0.
REQ-037 With order_ready held 0 and a sell issued: order_valid stays high for 32 cycles, then drops; timeout_err=1, halted=1, position=0.
REQ-038 With buy and sell high in the same cycle: no order_valid, no limit_hit.
REQ-039 With kill asserted on the handshake edge: position updates and halted=1 next cycle; after kill=0 and enable=0, the FSM returns to IDLE.
REQ-040 With rst asserted mid-REQ between clock edges: order_valid=0 and position=0 immediately.
